ed_threshold_ctrl: RTL and testbench
====================================

ED_THRESHOLD_CTRL -- requirements
Module: ed_threshold_ctrl

Interface
REQ-001 SHALL have parameter TRAIN_LOG2, default 8, log2 of training window length in valid samples.
REQ-002 SHALL have parameter SCALE_SHIFT, default 3, left shift applied to the training mean to form the threshold.
REQ-003 SHALL have parameter THR_MIN, default 500, threshold floor and reset value.
REQ-004 SHALL have parameter REFRACT, default 16, number of valid samples ignored after a detection.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that begins training from IDLE.
REQ-008 SHALL have port retrain, input, 1, single-cycle pulse that restarts training.
REQ-009 SHALL have port energy_valid, input, 1, energy_in qualifier.
REQ-010 SHALL have port energy_in, input, 32, unsigned squared-difference sample from the ED datapath.
REQ-011 SHALL have port threshold, output, 32, current unsigned detection threshold.
REQ-012 SHALL have port thr_valid, output, 1, high while threshold is trained (RUN or REFRACT).
REQ-013 SHALL have port busy_training, output, 1, high in TRAIN and CALC.
REQ-014 SHALL have port spike_detected, output, 1, one-cycle detection pulse.
REQ-015 SHALL have port spike_count, output, 16, detections since last training start, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, TRAIN, CALC, RUN, REFRACT.
REQ-017 SHALL move IDLE->TRAIN on start; start SHALL be ignored in all other states.
REQ-018 SHALL, on entering TRAIN, clear a (32+TRAIN_LOG2)-bit accumulator, the sample counter and spike_count, and deassert thr_valid; threshold holds its last value.
REQ-019 SHALL, in TRAIN, add energy_in to the accumulator and increment the counter on each energy_valid cycle; cycles without energy_valid change nothing.
REQ-020 SHALL move TRAIN->CALC on the cycle the 2^TRAIN_LOG2-th valid sample is accumulated.
REQ-021 SHALL, in CALC (exactly one cycle), set threshold = max(THR_MIN, sat32((acc >> TRAIN_LOG2) << SCALE_SHIFT)), sat32 clamping to 32'hFFFF_FFFF, then go to RUN; energy_valid in CALC is dropped.
REQ-022 SHALL, in RUN, on energy_valid with energy_in strictly greater than threshold, assert spike_detected on the next cycle for one cycle, increment spike_count (hold at 16'hFFFF), and enter REFRACT.
REQ-023 SHALL treat energy_in equal to threshold as no detection.
REQ-024 SHALL, in REFRACT, suppress detection and return to RUN after REFRACT valid samples; REFRACT=0 SHALL return to RUN on the next cycle.
REQ-025 SHALL, on retrain in TRAIN, CALC, RUN or REFRACT, enter TRAIN next cycle per REQ-018; retrain in IDLE SHALL be ignored.
REQ-026 SHALL give retrain priority over a simultaneous detection: no spike_detected pulse, no count increment.
REQ-027 SHALL not assert spike_detected outside RUN-originated detections.

Reset
REQ-028 SHALL, while rst_n is low, force state IDLE, threshold=THR_MIN, thr_valid=0, busy_training=0, spike_detected=0, spike_count=0, accumulator and counters 0.
REQ-029 SHALL, on reset assertion mid-training or mid-refractory, abandon the operation and require a new start after release.

Verification
REQ-030 SHALL verify: start, 256 valid samples of 100 -> CALC one cycle later, threshold=800, thr_valid=1, busy_training=0.
REQ-031 SHALL verify: trained at 800, samples 800 then 801 -> no pulse for 800, one-cycle pulse after 801, spike_count=1, next 16 valid samples of 5000 produce no pulse, 17th produces one.
REQ-032 SHALL verify: training on constant 10 -> threshold=500 (floor); training on constant 32'hFFFF_FFFF -> threshold=32'hFFFF_FFFF (saturation).
REQ-033 SHALL verify: energy_valid toggled every other cycle during training -> transition to CALC only after 256 valid samples.
REQ-034 SHALL verify: retrain coincident with sample 900 above threshold 800 in RUN -> no pulse, TRAIN entered, spike_count=0, thr_valid=0, threshold stays 800.
REQ-035 SHALL verify: rst_n low for one cycle at training sample 100 -> all outputs at reset values, start ignored not required, new start retrains from zero.

Source files
------------

// File: rtl/ed_threshold_ctrl.sv
// Energy-detector threshold controller: trains a mean-energy threshold over a
// window of valid samples, then flags samples that exceed it, with a
// refractory period after each detection.
module ed_threshold_ctrl #(
  parameter int TRAIN_LOG2  = 8,
  parameter int SCALE_SHIFT = 3,
  parameter int THR_MIN     = 500,
  parameter int REFRACT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        retrain,
  input  logic        energy_valid,
  input  logic [31:0] energy_in,
  output logic [31:0] threshold,
  output logic        thr_valid,
  output logic        busy_training,
  output logic        spike_detected,
  output logic [15:0] spike_count
);

  localparam int ACC_W = 32 + TRAIN_LOG2;
  localparam int WIDE_W = 32 + SCALE_SHIFT;
  localparam int REF_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [31:0] THR_FLOOR = 32'(THR_MIN);
  localparam logic [TRAIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'((REFRACT > 0) ? REFRACT - 1 : 0);

  typedef enum logic [2:0] {IDLE, TRAIN, CALC, RUN, REFR} state_t;

  state_t                state_q;
  logic [ACC_W-1:0]      acc_q;
  logic [TRAIN_LOG2-1:0] cnt_q;
  logic [REF_W-1:0]      refr_q;
  logic [31:0]           threshold_q;
  logic                  thr_valid_q;
  logic                  busy_q;
  logic                  spike_q;
  logic [15:0]           spike_cnt_q;

  logic [ACC_W-1:0]      acc_d;
  logic [31:0]           thr_d;

  // Clamp a widened value to the 32-bit threshold range.
  function automatic logic [31:0] sat32(input logic [WIDE_W-1:0] v);
    if ((v >> 32) != '0) return 32'hFFFF_FFFF;
    return v[31:0];
  endfunction

  // Detection counter holds at full scale instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Running sum and the scaled, floored mean that becomes the threshold.
  always_comb begin
    logic [31:0]       mean;
    logic [WIDE_W-1:0] wide;
    logic [31:0]       scaled;
    acc_d  = acc_q + ACC_W'(energy_in);
    mean   = acc_q[ACC_W-1:TRAIN_LOG2];
    wide   = WIDE_W'(mean) << SCALE_SHIFT;
    scaled = sat32(wide);
    thr_d  = (scaled > THR_FLOOR) ? scaled : THR_FLOOR;
  end

  // Control FSM with registered outputs; retrain outranks any detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      refr_q      <= '0;
      threshold_q <= THR_FLOOR;
      thr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      spike_q     <= 1'b0;
      spike_cnt_q <= '0;
    end else begin
      spike_q <= 1'b0;
      if ((retrain && state_q != IDLE) || (start && state_q == IDLE)) begin
        state_q     <= TRAIN;
        acc_q       <= '0;
        cnt_q       <= '0;
        refr_q      <= '0;
        spike_cnt_q <= '0;
        thr_valid_q <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          TRAIN: begin
            if (energy_valid) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CNT_LAST) state_q <= CALC;
            end
          end
          CALC: begin
            threshold_q <= thr_d;
            thr_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= RUN;
          end
          RUN: begin
            if (energy_valid && (energy_in > threshold_q)) begin
              spike_q     <= 1'b1;
              spike_cnt_q <= sat_inc16(spike_cnt_q);
              refr_q      <= '0;
              state_q     <= REFR;
            end
          end
          REFR: begin
            if (REFRACT == 0) begin
              state_q <= RUN;
            end else if (energy_valid) begin
              refr_q <= refr_q + 1'b1;
              if (refr_q == REF_LAST) state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign threshold      = threshold_q;
  assign thr_valid      = thr_valid_q;
  assign busy_training  = busy_q;
  assign spike_detected = spike_q;
  assign spike_count    = spike_cnt_q;

endmodule

// File: tb/tb_ed_threshold_ctrl.sv
// Directed bench for ed_threshold_ctrl: training, detection, refractory,
// floor/saturation, retrain priority and mid-training reset.
module tb_ed_threshold_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        retrain;
  logic        energy_valid;
  logic [31:0] energy_in;
  logic [31:0] threshold;
  logic        thr_valid;
  logic        busy_training;
  logic        spike_detected;
  logic [15:0] spike_count;

  int n_cmp;
  int n_err;

  ed_threshold_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .retrain        (retrain),
    .energy_valid   (energy_valid),
    .energy_in      (energy_in),
    .threshold      (threshold),
    .thr_valid      (thr_valid),
    .busy_training  (busy_training),
    .spike_detected (spike_detected),
    .spike_count    (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [31:0] e);
    energy_valid = 1'b1;
    energy_in    = e;
    step();
    energy_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] e, input int n);
    for (int i = 0; i < n; i++) sample(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_retrain();
    retrain = 1'b1;
    step();
    retrain = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_thr"}, threshold, 32'd500);
    chk({tag, "_thr_valid"}, 32'(thr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy_training), 32'd0);
    chk({tag, "_spike"}, 32'(spike_detected), 32'd0);
    chk({tag, "_count"}, 32'(spike_count), 32'd0);
  endtask

  initial begin
    int bad;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    retrain = 1'b0;
    energy_valid = 1'b0;
    energy_in = '0;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // retrain in IDLE is ignored
    pulse_retrain();
    chk("idle_retrain_busy", 32'(busy_training), 32'd0);

    // basic training on 100 -> 800
    pulse_start();
    chk("train_busy", 32'(busy_training), 32'd1);
    feed(32'd100, 255);
    chk("train_255_busy", 32'(busy_training), 32'd1);
    sample(32'd100);
    chk("calc_busy", 32'(busy_training), 32'd1);
    chk("calc_thr_valid", 32'(thr_valid), 32'd0);
    step();
    chk("run_thr", threshold, 32'd800);
    chk("run_thr_valid", 32'(thr_valid), 32'd1);
    chk("run_busy", 32'(busy_training), 32'd0);

    // equal is no detection, greater detects for one cycle
    sample(32'd800);
    chk("eq_no_spike", 32'(spike_detected), 32'd0);
    sample(32'd801);
    chk("gt_spike", 32'(spike_detected), 32'd1);
    chk("gt_count", 32'(spike_count), 32'd1);
    step();
    chk("spike_one_cycle", 32'(spike_detected), 32'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      sample(32'd5000);
      if (spike_detected !== 1'b0) bad++;
    end
    chk("refract_suppress", 32'(bad), 32'd0);
    sample(32'd5000);
    chk("refract_end_spike", 32'(spike_detected), 32'd1);
    chk("refract_end_count", 32'(spike_count), 32'd2);

    // start ignored while running refractory; return to RUN
    pulse_start();
    chk("start_ignored_busy", 32'(busy_training), 32'd0);
    feed(32'd0, 16);

    // retrain wins over a coincident detection
    retrain = 1'b1;
    sample(32'd900);
    retrain = 1'b0;
    chk("rt_no_spike", 32'(spike_detected), 32'd0);
    chk("rt_count", 32'(spike_count), 32'd0);
    chk("rt_thr_valid", 32'(thr_valid), 32'd0);
    chk("rt_thr_hold", threshold, 32'd800);
    chk("rt_busy", 32'(busy_training), 32'd1);

    // floor: constant 10 trains to 80, clamped up to 500
    feed(32'd10, 256);
    step();
    chk("floor_thr", threshold, 32'd500);
    chk("floor_thr_valid", 32'(thr_valid), 32'd1);

    // saturation on all-ones input
    pulse_retrain();
    feed(32'hFFFF_FFFF, 256);
    step();
    chk("sat_thr", threshold, 32'hFFFF_FFFF);

    // gapped valid: 255 samples with gaps must not finish training
    pulse_retrain();
    for (int i = 0; i < 255; i++) begin
      sample(32'd200);
      step();
    end
    step();
    chk("gap_255_thr_valid", 32'(thr_valid), 32'd0);
    chk("gap_255_busy", 32'(busy_training), 32'd1);
    sample(32'd200);
    step();
    chk("gap_256_thr", threshold, 32'd1600);
    chk("gap_256_thr_valid", 32'(thr_valid), 32'd1);

    // reset at training sample 100 abandons training
    pulse_retrain();
    feed(32'd100, 99);
    energy_valid = 1'b1;
    energy_in = 32'd100;
    rst_n = 1'b0;
    step();
    energy_valid = 1'b0;
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    feed(32'd100, 300);
    chk("no_start_busy", 32'(busy_training), 32'd0);
    chk("no_start_thr_valid", 32'(thr_valid), 32'd0);
    pulse_start();
    feed(32'd100, 256);
    step();
    chk("retrain_after_reset_thr", threshold, 32'd800);
    chk("retrain_after_reset_valid", 32'(thr_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
